udp_payload_packer: RTL
=======================

Name: udp_payload_packer

Overview:
Upstream feeder for ethernet_udp_transmit. Accepts a byte stream under a valid/ready handshake and packs it into double-buffered DATA_BYTES-wide payload words. It drives the transmitter's data/send inputs and watches its ready output, so one buffer fills while the other is held stable for transmission. Partial payloads are flushed on an explicit last marker or after an idle timeout, padded to full width.

Parameters:
DATA_BYTES, 16, payload width in bytes; must equal the transmitter's DATA_BYTES; >= 2.
TIMEOUT_CYCLES, 1000000, idle cycles before a partial buffer is flushed; 0 disables the timeout.
PAD_BYTE, 8'h00, fill value for unused payload bytes.

Ports:
clk  in  1  system clock (100 MHz); single clock domain.
reset  in  1  asynchronous, active-high reset.
in_data  in  8  stream byte.
in_valid  in  1  in_data valid.
in_ready  out  1  packer can accept a byte this cycle.
in_last  in  1  qualifies the accepted byte as end of payload; forces a flush.
data  out  8*DATA_BYTES  payload to transmitter; byte i on data[8*i+:8]; byte 0 is the first received.
data_len  out  $clog2(DATA_BYTES+1)  count of real (unpadded) bytes in data.
send  out  1  request to transmitter.
tx_ready  in  1  transmitter idle/ready.
frame_count  out  16  payloads completed; wraps.

Behaviour:
- Reset values: in_ready=1, send=0, data=all PAD_BYTE, data_len=0, frame_count=0. Both banks empty; write bank wb=0, read bank rb=0; wptr=0; TX FSM=TX_IDLE; timeout counter=0.
- Reset mid-operation discards all buffered bytes; no partial flush; send drops asynchronously.
- Storage: two banks of DATA_BYTES bytes, each with a full flag and stored length.
- Accept: in_ready = ~full[wb] (combinational). A byte is accepted when in_valid && in_ready. It writes bank[wb][wptr], then wptr increments.
- Commit of wb occurs on any of the following:
  (a) an accepted byte fills slot DATA_BYTES-1;
  (b) an accepted byte has in_last=1 (that byte is included);
  (c) timeout.
  On commit: full[wb]<=1, len[wb]<=bytes written, wb toggles, wptr<=0, timeout counter cleared.
- in_last on a non-accepted cycle is ignored. A commit never occurs with zero bytes.
- Timeout: the counter runs only while wptr>0 and no byte is accepted; it clears on every accepted byte. The counter reaching TIMEOUT_CYCLES commits on the next clock edge.
- Output mux: data byte i = bank[rb][i] if i < len[rb], else PAD_BYTE; data_len = len[rb] when full[rb], else 0. data is stable from send assertion until release.
- TX FSM:
  - TX_IDLE: if full[rb] && tx_ready, go to TX_REQ; send goes high on the next cycle (1-cycle latency from commit when idle).
  - TX_REQ: send=1; hold until tx_ready==0 (accepted, tolerates a divided transmitter clock); then go to TX_BUSY with send=0.
  - TX_BUSY: wait for tx_ready==1. Release: full[rb]<=0, rb toggles, frame_count+1 (mod 2^16), go to TX_IDLE.
- Simultaneous events:
  - Commit and release in the same cycle act on different banks; both take effect.
  - With both banks full, in_ready=0 until release; in_ready returns on the cycle after release.
  - Back-to-back payloads: the second send may assert 1 cycle after release if the other bank is full.
- Byte ordering across payloads is strictly FIFO; no bytes are dropped or duplicated.

Test Plan:
- Stream bytes 0x00..0x0F continuously with tx_ready modelled (falls 3 cycles after send, rises 50 later) -> data[8*i+:8]=i, data_len=16, send held until tx_ready low, frame_count=1.
- 5 bytes 0xA0..0xA4, in_last on 0xA4 -> data_len=5; bytes 5..15 = 0x00; send asserted 1 cycle after commit.
- tx_ready stuck low, offer 40 bytes back-to-back -> in_ready drops after 32 accepted; after tx_ready rises, payloads 0..15 then 16..31 go out in order, then 32..39 accepted.
- TIMEOUT_CYCLES=100: 3 bytes then idle -> commit 100 cycles after last byte, data_len=3; with TIMEOUT_CYCLES=0 no commit after 10000 cycles.
- Assert reset while in TX_BUSY with second bank full -> send=0, in_ready=1, data_len=0, frame_count=0 immediately; next 16 bytes transmit normally.
- Run 65537 payloads -> frame_count wraps to 1.

Source files
------------

// File: rtl/udp_payload_packer.sv
// Byte-stream to payload-word packer feeding ethernet_udp_transmit.
// Two banks alternate: one fills from the stream while the other is held for the transmitter.
module udp_payload_packer #(
  parameter int unsigned DATA_BYTES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  PAD_BYTE       = 8'h00
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [7:0]                          in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  output logic [8*DATA_BYTES-1:0]             data,
  output logic [$clog2(DATA_BYTES+1)-1:0]     data_len,
  output logic                                send,
  input  logic                                tx_ready,
  output logic [15:0]                         frame_count
);

  localparam int unsigned LW = $clog2(DATA_BYTES+1);
  localparam int unsigned PW = $clog2(DATA_BYTES);

  typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_BUSY} tx_state_e;

  logic [7:0]    bank_q [2][DATA_BYTES];
  logic [1:0]    full_q, full_d;
  logic [LW-1:0] len_q [2];
  logic [LW-1:0] len_d [2];
  logic          wb_q, wb_d, rb_q, rb_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [31:0]   tcnt_q, tcnt_d;
  tx_state_e     state_q, state_d;
  logic          send_q, send_d;
  logic [15:0]   fc_q, fc_d;
  logic          accept;
  logic          commit;
  logic [LW-1:0] commit_len;

  assign in_ready    = ~full_q[wb_q];
  assign accept      = in_valid & ~full_q[wb_q];
  assign send        = send_q;
  assign frame_count = fc_q;
  assign data_len    = full_q[rb_q] ? len_q[rb_q] : '0;

  always_comb begin
    data = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++)
      data[8*i +: 8] = (LW'(i) < len_q[rb_q]) ? bank_q[rb_q][PW'(i)] : PAD_BYTE;
  end

  always_comb begin
    full_d     = full_q;
    len_d      = len_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    wptr_d     = wptr_q;
    tcnt_d     = tcnt_q;
    state_d    = state_q;
    send_d     = send_q;
    fc_d       = fc_q;
    commit     = 1'b0;
    commit_len = '0;

    if (accept) begin
      tcnt_d = '0;
      if (in_last || wptr_q == PW'(DATA_BYTES-1)) begin
        commit     = 1'b1;
        commit_len = LW'(wptr_q) + LW'(1);
      end else begin
        wptr_d = wptr_q + PW'(1);
      end
    end else if (wptr_q != '0 && TIMEOUT_CYCLES != 0) begin
      // Timer only runs with a partial payload pending; zero bytes never commit.
      if (tcnt_q == TIMEOUT_CYCLES) begin
        commit     = 1'b1;
        commit_len = LW'(wptr_q);
      end else begin
        tcnt_d = tcnt_q + 32'd1;
      end
    end

    if (commit) begin
      full_d[wb_q] = 1'b1;
      len_d[wb_q]  = commit_len;
      wb_d         = ~wb_q;
      wptr_d       = '0;
      tcnt_d       = '0;
    end

    // Release acts on rb, commit on wb; they never coincide on the same bank.
    case (state_q)
      TX_IDLE: if (full_q[rb_q] && tx_ready) begin
        state_d = TX_REQ;
        send_d  = 1'b1;
      end
      TX_REQ: if (!tx_ready) begin
        state_d = TX_BUSY;
        send_d  = 1'b0;
      end
      TX_BUSY: if (tx_ready) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        fc_d         = fc_q + 16'd1;
        state_d      = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
        send_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q  <= '0;
      len_q   <= '{default: '0};
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      wptr_q  <= '0;
      tcnt_q  <= '0;
      state_q <= TX_IDLE;
      send_q  <= 1'b0;
      fc_q    <= '0;
    end else begin
      full_q  <= full_d;
      len_q   <= len_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      wptr_q  <= wptr_d;
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      send_q  <= send_d;
      fc_q    <= fc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) bank_q[wb_q][wptr_q] <= in_data;
  end

endmodule
